// File: rtl/store_demux_1x4.sv
// store_demux_1x4: one-producer, four-consumer routing stage.
// A word plus a 2-bit destination index is captured into a single output
// register and presented on a shared data bus. A one-hot out_valid marks the
// addressed consumer. The stage sustains one word per cycle while the
// addressed consumer is ready.
//
// Optional feature: define STORE_DEMUX_CNT_EN to add the out_cnt port. It
// carries four saturating per-output transfer counters of CNT_W bits each.
// Without the macro, the port, the CNT_W parameter and the counters are absent.
// Routing behaviour is identical in both builds.
//
// Handshake (both sides): a transfer happens at a rising edge where valid and
// ready are both high. out_valid/out_data stay stable while the addressed
// out_ready is low. in_ready is combinational from out_ready so a delivery
// and a new accept can share one cycle.
//
// The FSM state lives in state_q (IDLE/HOLD) and can be probed by checkers.
module store_demux_1x4 #(
  parameter int DATA_W = 32
`ifdef STORE_DEMUX_CNT_EN
  ,
  parameter int CNT_W  = 8
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_sel,
  input  logic [DATA_W-1:0] in_data,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef STORE_DEMUX_CNT_EN
  ,
  output logic [4*CNT_W-1:0] out_cnt
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          sel_q, sel_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [3:0]          out_valid_q, out_valid_d;

  logic                accept;
  logic                xfer;

  // Handshake qualifiers. Only the addressed consumer's ready is considered.
  always_comb begin
    xfer     = (state_q == HOLD) && out_ready[sel_q];
    in_ready = (state_q == IDLE) || out_ready[sel_q];
    accept   = in_valid && in_ready;
  end

  // Next-state, next-register values. A new word wins over a drain to IDLE.
  // On a drain, out_data keeps its last delivered value.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    out_data_d = out_data_q;
    if (accept) begin
      state_d    = HOLD;
      sel_d      = in_sel;
      out_data_d = in_data;
    end else if (xfer) begin
      state_d    = IDLE;
    end
    out_valid_d = (state_d == HOLD) ? (4'b0001 << sel_d) : 4'b0000;
  end

  // FSM and output registers. Reset drops any held word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= 2'd0;
      out_data_q  <= '0;
      out_valid_q <= 4'b0000;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef STORE_DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  // Count completed deliveries per output. Each counter sticks at all-ones.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      cnt_d[n] = cnt_q[n];
      if (xfer && (sel_q == 2'(n)) && (cnt_q[n] != {CNT_W{1'b1}})) begin
        cnt_d[n] = cnt_q[n] + 1'b1;
      end
    end
  end

  // Counter registers, cleared with the routing state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < 4; n++) cnt_q[n] <= '0;
    end else begin
      for (int n = 0; n < 4; n++) cnt_q[n] <= cnt_d[n];
    end
  end

  // Pack channel n into out_cnt[n*CNT_W +: CNT_W].
  always_comb begin
    out_cnt = '0;
    for (int n = 0; n < 4; n++) out_cnt[n*CNT_W +: CNT_W] = cnt_q[n];
  end
`endif

endmodule

// File: tb/tb_store_demux_1x4.sv
// Directed bench for store_demux_1x4.
// Inputs change 1ns after the rising edge, and outputs are sampled there as well.
// The counter scenario is built only when STORE_DEMUX_CNT_EN is defined.
module tb_store_demux_1x4;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_sel;
  logic [DATA_W-1:0] in_data;
  logic [3:0]        out_valid;
  logic [3:0]        out_ready;
  logic [DATA_W-1:0] out_data;
`ifdef STORE_DEMUX_CNT_EN
  logic [4*CNT_W-1:0] out_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // clock / reset block
  always #5 clk = ~clk;

  store_demux_1x4 #(
    .DATA_W(DATA_W)
`ifdef STORE_DEMUX_CNT_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef STORE_DEMUX_CNT_EN
    , .out_cnt (out_cnt)
`endif
  );

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = '0; out_ready = 4'b1111;
    step(); step();
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid got %b exp 0000", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 00000000", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    out_ready = 4'b1111;
    in_valid = 1'b1; in_sel = 2'd2; in_data = 32'hDEADBEEF;
    step();
    in_valid = 1'b0; in_data = 32'h0BADF00D;
    checks++; if (out_valid !== 4'b0100) begin errors++; $display("FAIL single_valid got %b exp 0100", out_valid); end
    checks++; if (out_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data got %h exp deadbeef", out_data); end
    step();
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL single_drain got %b exp 0000", out_valid); end
    checks++; if (out_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_retain got %h exp deadbeef", out_data); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_v;
    out_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_sel = 2'(i); in_data = 32'hA0 + 32'(i);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d] got %b exp 1", i, in_ready); end
      step();
      exp_v = 4'b0001 << i;
      checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL b2b_valid[%0d] got %b exp %b", i, out_valid, exp_v); end
      checks++; if (out_data !== 32'hA0 + 32'(i)) begin errors++; $display("FAIL b2b_data[%0d] got %h exp %h", i, out_data, 32'hA0 + 32'(i)); end
    end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL b2b_drain got %b exp 0000", out_valid); end
  endtask

  task automatic test_stall();
    out_ready = 4'b1101;
    in_valid = 1'b1; in_sel = 2'd1; in_data = 32'h1234;
    step();
    in_valid = 1'b1; in_sel = 2'd3; in_data = 32'h5555;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (out_valid !== 4'b0010) begin errors++; $display("FAIL stall_valid[%0d] got %b exp 0010", c, out_valid); end
      checks++; if (out_data !== 32'h1234) begin errors++; $display("FAIL stall_data[%0d] got %h exp 00001234", c, out_data); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d] got %b exp 0", c, in_ready); end
      step();
    end
    out_ready = 4'b1111;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %b exp 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 4'b1000) begin errors++; $display("FAIL stall_next_valid got %b exp 1000", out_valid); end
    checks++; if (out_data !== 32'h5555) begin errors++; $display("FAIL stall_next_data got %h exp 00005555", out_data); end
    step();
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL stall_drain got %b exp 0000", out_valid); end
  endtask

  task automatic test_reset_hold();
    out_ready = 4'b0111;
    in_valid = 1'b1; in_sel = 2'd3; in_data = 32'h77;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 4'b1000) begin errors++; $display("FAIL rsthold_valid got %b exp 1000", out_valid); end
    rst = 1'b1;
    step();
    rst = 1'b0; out_ready = 4'b1111;
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL rsthold_cleared got %b exp 0000", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rsthold_data got %h exp 00000000", out_data); end
    step();
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL rsthold_lost got %b exp 0000", out_valid); end
  endtask

  task automatic test_ignore_invalid();
    out_ready = 4'b1111;
    in_valid = 1'b1; in_sel = 2'd0; in_data = 32'hCAFE;
    step();
    in_valid = 1'b0; in_sel = 2'd1; in_data = 32'hFFFF_FFFF;
    step(); step();
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL ignore_valid got %b exp 0000", out_valid); end
    checks++; if (out_data !== 32'hCAFE) begin errors++; $display("FAIL ignore_data got %h exp 0000cafe", out_data); end
  endtask

`ifdef STORE_DEMUX_CNT_EN
  task automatic test_counters();
    rst = 1'b1; in_valid = 1'b0; out_ready = 4'b1111;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_sel = 2'd3; in_data = 32'(i);
      step();
    end
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1; in_sel = 2'd0; in_data = 32'(i);
      step();
    end
    in_valid = 1'b0;
    step(); step();
    checks++; if (out_cnt[3*CNT_W +: CNT_W] !== 8'd3) begin errors++; $display("FAIL cnt_ch3 got %0d exp 3", out_cnt[3*CNT_W +: CNT_W]); end
    checks++; if (out_cnt[0 +: CNT_W] !== 8'd255) begin errors++; $display("FAIL cnt_ch0 got %0d exp 255", out_cnt[0 +: CNT_W]); end
    checks++; if (out_cnt[1*CNT_W +: CNT_W] !== 8'd0) begin errors++; $display("FAIL cnt_ch1 got %0d exp 0", out_cnt[1*CNT_W +: CNT_W]); end
    checks++; if (out_cnt[2*CNT_W +: CNT_W] !== 8'd0) begin errors++; $display("FAIL cnt_ch2 got %0d exp 0", out_cnt[2*CNT_W +: CNT_W]); end
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = '0; out_ready = 4'b0000;
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_hold();
    test_ignore_invalid();
`ifdef STORE_DEMUX_CNT_EN
    test_counters();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
